mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative MIPS multiply/divide unit with architectural HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [WORD_WIDTH-1:0] src_a,
    input  logic [WORD_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] hi,
    output logic [WORD_WIDTH-1:0] lo
);

    localparam int W     = WORD_WIDTH;
    localparam int CNT_W = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_signed_q, is_signed_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             in_neg_a, in_neg_b;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_trial;
    logic [2*W-1:0]   prod_final;
    logic [W-1:0]     quo_final;
    logic [W-1:0]     rem_final;

    // Signed requests work on magnitudes; signs are reapplied in SIGN.
    assign in_neg_a = ~op[0] & src_a[W-1];
    assign in_neg_b = ~op[0] & src_b[W-1];
    assign mag_a    = in_neg_a ? -src_a : src_a;
    assign mag_b    = in_neg_b ? -src_b : src_b;

    // Multiply: multiplier sits in acc low half and shifts out LSB-first.
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: dividend sits in acc low half, quotient bits shift in behind it.
    assign div_shift = {rem_q, acc_q[W-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    assign prod_final = (is_signed_q && (neg_a_q ^ neg_b_q)) ? -acc_q : acc_q;
    // A zero divisor would otherwise yield all-ones negated by the dividend sign.
    assign quo_final  = (opnd_q == '0) ? {W{1'b1}} :
                        (is_signed_q && (neg_a_q ^ neg_b_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_final  = (is_signed_q && neg_a_q) ? -rem_q : rem_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_signed_d = is_signed_q;
        is_div_d    = is_div_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'b100: hi_d = src_a;
                        3'b101: lo_d = src_a;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_signed_d = ~op[0];
                            is_div_d    = op[1];
                            neg_a_d     = in_neg_a;
                            neg_b_d     = in_neg_b;
                            opnd_d      = mag_b;
                            acc_d       = {{W{1'b0}}, mag_a};
                            rem_d       = '0;
                            cnt_d       = '0;
                            busy_d      = 1'b1;
                            state_d     = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (is_div_q) begin
                    rem_d = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
                    acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_trial[W]};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W-1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (is_div_q) begin
                    hi_d = rem_final;
                    lo_d = quo_final;
                end else begin
                    hi_d = prod_final[2*W-1:W];
                    lo_d = prod_final[W-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_signed_q <= 1'b0;
            is_div_q    <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_signed_q <= is_signed_d;
            is_div_q    <= is_div_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    int n_busy;
    int n_pre;

    mul_div_unit #(.WORD_WIDTH(32)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is taken on the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Counts falling-edge samples with busy=1; returns on the done cycle.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        issue(o, a, b);
        wait_done(n_busy);
        check({tag, "_busy_cycles"}, n_busy, 32'd33);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        RST_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        src_a = '0;
        src_b = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        RST_n = 1'b1;
        @(negedge CLK);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge CLK);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_by0", OP_DIV, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_neg_by0", OP_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

        // MTHI arriving mid-operation must be dropped.
        issue(OP_DIVU, 32'd10, 32'd3);
        repeat (4) @(negedge CLK);
        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        check("hi_stable_busy", hi, 32'hFFFF_FF9C);
        wait_done(n_busy);
        check("mthi_busy_cycles", n_busy + 5, 32'd33);
        check("mthi_ign_done", {31'd0, done}, 32'd1);
        check("mthi_ign_hi", hi, 32'd1);
        check("mthi_ign_lo", lo, 32'd3);

        // Issued in the done cycle: back-to-back acceptance.
        run_op("b2b_multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_hi", hi, 32'd0);
        check("rsvd_lo", lo, 32'd12);

        issue(OP_MTLO, 32'h0000_ABCD, 32'd0);
        check("mtlo_lo", lo, 32'h0000_ABCD);
        check("mtlo_hi", hi, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mtlo_done", {31'd0, done}, 32'd0);

        issue(OP_MTHI, 32'h5555_AAAA, 32'd0);
        check("mthi_hi", hi, 32'h5555_AAAA);
        check("mthi_lo", lo, 32'h0000_ABCD);

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULT, 32'd6, 32'd7);
        n_pre = 1;
        repeat (9) begin
            @(negedge CLK);
            n_pre++;
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        RST_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        check("postrst_busy", {31'd0, busy}, 32'd0);

        run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
